seg_display_scan: RTL and testbench
===================================

// Module: seg_display_scan
// PURPOSE
//   Downstream debug/display stage for the multi-cycle RISC-V core. Takes the core's
//   observable datapath words and drives the board's 8-digit 7-seg display and 17 LEDs.
//   A 3-bit switch selects which 32-bit word is shown as 8 hex digits.
//   Time-multiplexed scan; the shown word is snapshotted per frame so digits never tear.
// PARAMETERS
//   SCAN_DIV   100000  clk cycles per digit slot (>=2); 1 ms at 100 MHz
//   HB_FRAMES  125     full 8-digit frames per heartbeat LED toggle (>=1)
// PORTS
//   clk     in   1   system clock, all state on rising edge
//   rst_    in   1   asynchronous, active-HIGH reset (rst_=1 resets)
//   switch  in   3   word select, asynchronous to clk
//   pc      in   32  program counter
//   ir      in   32  instruction register
//   alu_f   in   32  registered ALU result F
//   mdr     in   32  memory data register
//   reg_a   in   32  operand register A
//   reg_b   in   32  operand register B
//   w_data  in   32  regfile write data
//   flags   in   4   {ZF,SF,CF,OF}
//   AN      out  8   digit enables, active-low, one-hot-low
//   Seg     out  8   segments {dp,g,f,e,d,c,b,a}, active-low
//   Led     out  17  status LEDs
// BEHAVIOUR
//   Reset: AN=8'hFF, Seg=8'hFF, Led=0; prescaler, digit index, frame count, snapshot,
//     switch synchroniser all 0.
//   switch -> 2-FF synchroniser -> sel; sel_prev register holds last sel.
//   Source map sel: 0 pc,1 ir,2 alu_f,3 mdr,4 reg_a,5 reg_b,6 w_data,7 {28'b0,flags}.
//   Prescaler counts 0..SCAN_DIV-1, wraps to 0; at SCAN_DIV-1 digit index (3b) increments,
//     7 wraps to 0.
//   Snapshot reload: on cycle where digit index wraps 7->0, OR cycle after sel!=sel_prev
//     (immediate reload, prescaler and digit index not disturbed). Both same cycle: one reload.
//   Frame counter counts 7->0 wraps; at HB_FRAMES-1 wraps to 0 and toggles heartbeat.
//   Outputs registered: AN/Seg reflect digit index one clk after it changes.
//     AN[i]=0 only for current index i; digit i shows snapshot[4i+3:4i] (digit 0 rightmost).
//   Hex decode active-low 0-F, standard a-g; dp (Seg[7]) always 1 (off).
//   Led[3:0]=flags live (unsnapshotted, registered 1 clk); Led[6:4]=sel;
//     Led[14:7]=pc[9:2] live registered; Led[15]=0; Led[16]=heartbeat.
//   Reset mid-scan: immediate async return to reset values; first digit after release is
//     digit 0 with snapshot 0 until the first reload.
//   Snapshot 0 after reset is shown as "00000000" until reload (one cycle after sel
//     changes or at first frame wrap).
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: digit i (i>=1) blanked (Seg=8'hFF, AN still driven)
//     when snapshot[31:4i]==0; digit 0 always shown, so value 0 shows single "0".
//   Undefined: all 8 digits always shown, leading zeros included.
// TESTING (bench uses SCAN_DIV=4, HB_FRAMES=2)
//   Reset held, any inputs -> AN=FF, Seg=FF, Led=0; release -> AN=FE within 2 clk, digit 0.
//   switch=0, pc=32'h0000_1234, run 2 frames -> AN walks FE,FD,..,7F every 4 clk;
//     Seg = 99('4'),B0('3'),A4('2'),F9('1'),C0('0')x4.
//   switch 0->1 mid-frame, ir=32'hDEAD_BEEF -> within 3 clk snapshot=DEADBEEF, current
//     digit shows new nibble, AN sequence not reset.
//   pc changes mid-frame without switch change -> displayed digits unchanged until 7->0 wrap.
//   switch=7, flags=4'b1010 -> Led[3:0]=1010, Led[6:4]=7, Led[16] toggles every 64 clk.
//   LEADING_ZERO_BLANK_EN, alu_f=0x00A0 -> digits 7..2 Seg=FF, digit1=88('A'), digit0=C0.

Source files
------------

// File: rtl/seg_display_scan.sv
// Scanned 8-digit hex display of a selectable core datapath word, plus status LEDs.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg_display_scan #(
  parameter int SCAN_DIV  = 100000,
  parameter int HB_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic [2:0]  switch,
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic [31:0] alu_f,
  input  logic [31:0] mdr,
  input  logic [31:0] reg_a,
  input  logic [31:0] reg_b,
  input  logic [31:0] w_data,
  input  logic [3:0]  flags,
  output logic [7:0]  AN,
  output logic [7:0]  Seg,
  output logic [16:0] Led
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (HB_FRAMES > 1) ? $clog2(HB_FRAMES) : 1;

  logic [2:0]    sw_meta_q, sel_q, sel_prev_q;
  logic [PW-1:0] presc_q;
  logic [2:0]    digit_q;
  logic [FW-1:0] frame_q;
  logic          hb_q;
  logic [31:0]   snap_q;
  logic [7:0]    an_q, seg_q;
  logic [16:0]   led_q;

  logic [31:0]   src_word;
  logic [31:0]   shifted_d;
  logic          slot_end, frame_end, reload, blank;
  logic [7:0]    seg_d;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
      4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
      4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
      4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_comb begin
    src_word = 32'd0;
    case (sel_q)
      3'd0: src_word = pc;
      3'd1: src_word = ir;
      3'd2: src_word = alu_f;
      3'd3: src_word = mdr;
      3'd4: src_word = reg_a;
      3'd5: src_word = reg_b;
      3'd6: src_word = w_data;
      default: src_word = {28'd0, flags};
    endcase
  end

  // A select change reloads immediately; the scan timing keeps running undisturbed.
  always_comb begin
    slot_end  = (presc_q == PW'(SCAN_DIV - 1));
    frame_end = slot_end && (digit_q == 3'd7);
    reload    = frame_end || (sel_q != sel_prev_q);
    shifted_d = snap_q >> {digit_q, 2'b00};
`ifdef LEADING_ZERO_BLANK_EN
    blank     = (digit_q != 3'd0) && (shifted_d == 32'd0);
`else
    blank     = 1'b0;
`endif
    seg_d     = blank ? 8'hFF : hex_to_seg(shifted_d[3:0]);
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      sw_meta_q  <= '0;
      sel_q      <= '0;
      sel_prev_q <= '0;
      presc_q    <= '0;
      digit_q    <= '0;
      frame_q    <= '0;
      hb_q       <= 1'b0;
      snap_q     <= '0;
      an_q       <= 8'hFF;
      seg_q      <= 8'hFF;
      led_q      <= '0;
    end else begin
      sw_meta_q  <= switch;
      sel_q      <= sw_meta_q;
      sel_prev_q <= sel_q;
      presc_q    <= slot_end ? '0 : presc_q + 1'b1;
      if (slot_end) digit_q <= digit_q + 3'd1;
      if (frame_end) begin
        if (frame_q == FW'(HB_FRAMES - 1)) begin
          frame_q <= '0;
          hb_q    <= ~hb_q;
        end else begin
          frame_q <= frame_q + 1'b1;
        end
      end
      if (reload) snap_q <= src_word;
      an_q  <= ~(8'd1 << digit_q);
      seg_q <= seg_d;
      led_q <= {hb_q, 1'b0, pc[9:2], sel_q, flags};
    end
  end

  assign AN  = an_q;
  assign Seg = seg_q;
  assign Led = led_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: directed table of displayed words, corner sequences,
// and random traffic checked against a cycle-index arithmetic model.
module tb_seg_display_scan;
  localparam int SD    = 4;
  localparam int HB    = 2;
  localparam int FRAME = 8 * SD;
  localparam int MAXC  = 2048;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] Z = 8'hFF;
`else
  localparam logic [7:0] Z = 8'hC0;
`endif

  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic [2:0]  switch = '0;
  logic [31:0] pc = '0, ir = '0, alu_f = '0, mdr = '0, reg_a = '0, reg_b = '0, w_data = '0;
  logic [3:0]  flags = '0;
  logic [7:0]  AN, Seg;
  logic [16:0] Led;

  always #5 clk = ~clk;

  seg_display_scan #(.SCAN_DIV(SD), .HB_FRAMES(HB)) dut (
    .clk(clk), .rst_(rst_), .switch(switch), .pc(pc), .ir(ir), .alu_f(alu_f),
    .mdr(mdr), .reg_a(reg_a), .reg_b(reg_b), .w_data(w_data), .flags(flags),
    .AN(AN), .Seg(Seg), .Led(Led)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [2:0]  sw_h   [MAXC];
  logic [31:0] src_h  [MAXC][8];
  logic [31:0] snap_h [MAXC];
  logic [7:0]  seg_lut[16];

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] word;
    logic [7:0]  exp_seg[8];
  } vec_t;
  vec_t tab[6];

  function automatic logic [2:0] sw_at(int k);
    return (k < 1) ? 3'd0 : sw_h[k];
  endfunction

  function automatic logic [7:0] exp_seg(logic [31:0] w, int d);
    logic [31:0] sh;
    sh = w >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d != 0 && sh == 32'd0) return 8'hFF;
`endif
    return seg_lut[sh[3:0]];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_   = 1'b1;
    switch = 3'($urandom_range(0, 7));
    pc     = $urandom;
    flags  = 4'($urandom);
    #1;
    check("rst_an", {24'd0, AN}, 32'h0000_00FF);
    check("rst_seg", {24'd0, Seg}, 32'h0000_00FF);
    check("rst_led", {15'd0, Led}, 32'd0);
    @(negedge clk);
    check("rst_hold_an", {24'd0, AN}, 32'h0000_00FF);
    rst_      = 1'b0;
    cyc       = 0;
    snap_h[0] = 32'd0;
  endtask

  // Called at a falling edge; applies inputs, clocks once, checks at the next falling edge.
  task automatic step(input logic [2:0] sw, input logic [31:0] p, input logic [31:0] i,
                      input logic [31:0] a, input logic [31:0] m, input logic [31:0] ra,
                      input logic [31:0] rb, input logic [31:0] wd, input logic [3:0] fl);
    int d;
    int hb;
    if (cyc >= MAXC - 1) begin
      $display("FAIL model_overflow cyc=%0d actual=%0d expected<%0d", cyc, cyc, MAXC - 1);
      $fatal(1, "model history exhausted");
    end
    switch = sw; pc = p; ir = i; alu_f = a; mdr = m; reg_a = ra; reg_b = rb; w_data = wd;
    flags = fl;
    cyc++;
    sw_h[cyc] = sw;
    src_h[cyc][0] = p;  src_h[cyc][1] = i;  src_h[cyc][2] = a;  src_h[cyc][3] = m;
    src_h[cyc][4] = ra; src_h[cyc][5] = rb; src_h[cyc][6] = wd; src_h[cyc][7] = {28'd0, fl};
    if ((cyc % FRAME == 0) || (sw_at(cyc - 2) != sw_at(cyc - 3)))
      snap_h[cyc] = src_h[cyc][sw_at(cyc - 2)];
    else
      snap_h[cyc] = snap_h[cyc - 1];
    @(posedge clk);
    @(negedge clk);
    d  = ((cyc - 1) / SD) % 8;
    hb = ((cyc - 1) / FRAME / HB) % 2;
    check("an", {24'd0, AN}, {24'd0, ~(8'd1 << d)});
    check("seg", {24'd0, Seg}, {24'd0, exp_seg(snap_h[cyc - 1], d)});
    check("led", {15'd0, Led}, {15'd0, hb[0], 1'b0, p[9:2], sw_at(cyc - 2), fl});
  endtask

  task automatic rand_step(input logic [2:0] sw);
    step(sw, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
         4'($urandom));
  endtask

  initial begin
    logic [2:0] sw;
    int d0;
    seg_lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    tab[0] = '{3'd0, 32'h0000_1234, '{8'h99, 8'hB0, 8'hA4, 8'hF9, Z, Z, Z, Z}};
    tab[1] = '{3'd1, 32'hDEAD_BEEF, '{8'h8E, 8'h86, 8'h86, 8'h83, 8'hA1, 8'h88, 8'h86, 8'hA1}};
    tab[2] = '{3'd3, 32'h89AB_C567, '{8'hF8, 8'h82, 8'h92, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80}};
    tab[3] = '{3'd6, 32'h0000_0000, '{8'hC0, Z, Z, Z, Z, Z, Z, Z}};
    tab[4] = '{3'd2, 32'h0000_00A0, '{8'hC0, 8'h88, Z, Z, Z, Z, Z, Z}};
    tab[5] = '{3'd7, 32'h0000_000C, '{8'hC6, Z, Z, Z, Z, Z, Z, Z}};

    for (int e = 0; e < 6; e++) begin
      do_reset();
      for (int k = 1; k <= 2 * FRAME; k++) begin
        step(tab[e].sel, tab[e].word, tab[e].word, tab[e].word, tab[e].word, tab[e].word,
             tab[e].word, tab[e].word, tab[e].word[3:0]);
        if (k == 1) check("first_digit_an", {24'd0, AN}, 32'h0000_00FE);
        if (k <= FRAME && tab[e].sel == 3'd0 && (k - 1) % SD == 0)
          check("pre_reload_zero", {24'd0, Seg}, 32'h0000_00C0);
        if (k > FRAME && (k - 1) % SD == 0)
          check("tab_seg", {24'd0, Seg}, {24'd0, tab[e].exp_seg[((k - 1) / SD) % 8]});
      end
    end

    // Heartbeat and live status LEDs.
    do_reset();
    for (int k = 1; k <= 2 * FRAME + 1; k++) begin
      step(3'd7, 32'h0000_0000, '0, '0, '0, '0, '0, '0, 4'b1010);
      if (k == 2 * FRAME)     check("hb_before", {31'd0, Led[16]}, 32'd0);
      if (k == 2 * FRAME + 1) check("hb_after", {31'd0, Led[16]}, 32'd1);
      if (k == 2 * FRAME + 1) check("led_status", {25'd0, Led[6:0]}, {25'd0, 3'd7, 4'b1010});
    end

    // Select change mid-frame reloads at once without restarting the scan.
    do_reset();
    for (int k = 1; k <= FRAME + 9; k++)
      step(3'd0, $urandom, 32'hDEAD_BEEF, '0, '0, '0, '0, '0, 4'd0);
    for (int k = 1; k <= 4; k++)
      step(3'd1, $urandom, 32'hDEAD_BEEF, '0, '0, '0, '0, '0, 4'd0);
    d0 = ((cyc - 1) / SD) % 8;
    check("sw_change_an", {24'd0, AN}, {24'd0, ~(8'd1 << d0)});
    check("sw_change_seg", {24'd0, Seg}, {24'd0, exp_seg(32'hDEAD_BEEF, d0)});

    // pc moving without a select change must not tear the current frame.
    do_reset();
    for (int k = 1; k <= FRAME; k++)
      step(3'd0, 32'h1111_1111, '0, '0, '0, '0, '0, '0, 4'd0);
    for (int k = 1; k <= FRAME; k++) begin
      step(3'd0, 32'h2222_2222, '0, '0, '0, '0, '0, '0, 4'd0);
      if ((k - 1) % SD == 0) check("no_tear", {24'd0, Seg}, 32'h0000_00F9);
    end
    step(3'd0, 32'h2222_2222, '0, '0, '0, '0, '0, '0, 4'd0);
    check("next_frame", {24'd0, Seg}, 32'h0000_00A4);

    // Random traffic with occasional select changes and a reset in the middle of a scan.
    do_reset();
    sw = 3'd0;
    for (int k = 0; k < 700; k++) begin
      if ($urandom_range(0, 19) == 0) sw = 3'($urandom_range(0, 7));
      if (k == 333) do_reset();
      rand_step(sw);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
